// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and flag vector width.
package alu_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned FLAG_W   = 5;

    localparam logic [OPCODE_W-1:0] OP_ADD = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_ADC = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_INC = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_DEC = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_NOT = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_ROL = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_ROR = 4'd9;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_B = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_P = 3;
    localparam int unsigned FLAG_I = 4;

    // Arithmetic ops are the ones whose carry/borrow feeds the sticky CF.
    function automatic logic is_arith(input logic [OPCODE_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_DEC);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath.
// Ports: opcode/a/b/carry_in in; y and the flag vector {invalid_op, parity, zero, borrow, carry_out} out.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8
) (
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BUS_WIDTH-1:0] y,
    output logic [FLAG_W-1:0]    flags
);

    localparam int unsigned W = BUS_WIDTH;

    logic [W:0]   ext;
    logic [W-1:0] y_c;
    logic         carry_c;
    logic         borrow_c;
    logic         invalid_c;

    // Arithmetic at W+1 bits; the top bit is carry (add) or borrow (subtract).
    always_comb begin
        ext       = '0;
        y_c       = '0;
        carry_c   = 1'b0;
        borrow_c  = 1'b0;
        invalid_c = 1'b0;
        case (opcode)
            OP_ADD: begin
                ext     = {1'b0, a} + {1'b0, b};
                y_c     = ext[W-1:0];
                carry_c = ext[W];
            end
            OP_ADC: begin
                ext     = {1'b0, a} + {1'b0, b} + (W+1)'(carry_in);
                y_c     = ext[W-1:0];
                carry_c = ext[W];
            end
            OP_SUB: begin
                ext      = {1'b0, a} - {1'b0, b};
                y_c      = ext[W-1:0];
                borrow_c = ext[W];
            end
            OP_INC: begin
                ext     = {1'b0, a} + (W+1)'(1);
                y_c     = ext[W-1:0];
                carry_c = ext[W];
            end
            OP_DEC: begin
                ext      = {1'b0, a} - (W+1)'(1);
                y_c      = ext[W-1:0];
                borrow_c = ext[W];
            end
            OP_AND: y_c = a & b;
            OP_NOT: y_c = ~a;
            OP_ROL: y_c = {a[W-2:0], a[W-1]};
            OP_ROR: y_c = {a[0], a[W-1:1]};
            default: invalid_c = 1'b1;
        endcase
    end

    always_comb begin
        y             = y_c;
        flags         = '0;
        flags[FLAG_C] = carry_c;
        flags[FLAG_B] = borrow_c;
        flags[FLAG_Z] = (y_c == '0);
        flags[FLAG_P] = ^y_c;
        flags[FLAG_I] = invalid_c;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue/retire wrapper around alu_core with a sticky carry flag.
// Ports: in_valid/in_ready command handshake (opcode, a, b, in_use_cf, in_carry),
//        clear_cf, out_valid/out_ready result handshake (out_y, out_flags),
//        cf, and saturating op_count/err_count.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPCODE_W-1:0]  in_opcode,
    input  logic [BUS_WIDTH-1:0] in_a,
    input  logic [BUS_WIDTH-1:0] in_b,
    input  logic                 in_use_cf,
    input  logic                 in_carry,
    input  logic                 clear_cf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_y,
    output logic [FLAG_W-1:0]    out_flags,
    output logic                 cf,
    output logic [CNT_WIDTH-1:0] op_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    logic                 out_valid_q, out_valid_d;
    logic [BUS_WIDTH-1:0] out_y_q, out_y_d;
    logic [FLAG_W-1:0]    out_flags_q, out_flags_d;
    logic                 cf_q, cf_d;
    logic [CNT_WIDTH-1:0] op_count_q, op_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    logic                 accept_c;
    logic                 stall_c;
    logic                 cf_eff_c;
    logic                 carry_in_c;
    logic [BUS_WIDTH-1:0] core_y_c;
    logic [FLAG_W-1:0]    core_flags_c;

    // Ready passes straight through from downstream; the output register is the only storage.
    assign in_ready   = !out_valid_q || out_ready;
    assign accept_c   = in_valid && in_ready;
    assign stall_c    = out_valid_q && !out_ready;
    // A same-cycle clear is seen by the command being accepted.
    assign cf_eff_c   = clear_cf ? 1'b0 : cf_q;
    assign carry_in_c = in_use_cf ? cf_eff_c : in_carry;

    alu_core #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_core (
        .opcode   (in_opcode),
        .a        (in_a),
        .b        (in_b),
        .carry_in (carry_in_c),
        .y        (core_y_c),
        .flags    (core_flags_c)
    );

    // Next-state for the output register, CF and counters.
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_flags_d = out_flags_q;
        cf_d        = cf_q;
        op_count_d  = op_count_q;
        err_count_d = err_count_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (!stall_c) begin
            cf_d = cf_eff_c;
        end

        if (accept_c) begin
            out_valid_d = 1'b1;
            out_y_d     = core_y_c;
            out_flags_d = core_flags_c;
            if (is_arith(in_opcode)) begin
                cf_d = core_flags_c[FLAG_C] | core_flags_c[FLAG_B];
            end
            if (op_count_q != '1) begin
                op_count_d = op_count_q + CNT_WIDTH'(1);
            end
            if (core_flags_c[FLAG_I] && (err_count_q != '1)) begin
                err_count_d = err_count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_flags_q <= '0;
            cf_q        <= 1'b0;
            op_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_flags_q <= out_flags_d;
            cf_q        <= cf_d;
            op_count_q  <= op_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_flags = out_flags_q;
    assign cf        = cf_q;
    assign op_count  = op_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (BUS_WIDTH=8, CNT_WIDTH=4).
module tb_alu_issue_stage;

    localparam int unsigned BW = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [BW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic          in_use_cf;
    logic          in_carry;
    logic          clear_cf;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_y;
    logic [4:0]    out_flags;
    logic          cf;
    logic [CW-1:0] op_count;
    logic [CW-1:0] err_count;

    int checks;
    int errors;

    alu_issue_stage #(
        .BUS_WIDTH (BW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_use_cf (in_use_cf),
        .in_carry  (in_carry),
        .clear_cf  (clear_cf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_flags (out_flags),
        .cf        (cf),
        .op_count  (op_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted command with downstream always ready; returns 1 ns after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic use_cf, input logic carry, input logic clr);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_use_cf = use_cf;
        in_carry  = carry;
        clear_cf  = clr;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        clear_cf  = 1'b0;
        in_use_cf = 1'b0;
        in_carry  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0;
        in_use_cf = 1'b0; in_carry = 1'b0; clear_cf = 1'b0; out_ready = 1'b1;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_y !== 8'd0) begin errors++; $display("FAIL reset_out_y: got %0d expected 0", out_y); end
        checks++; if (out_flags !== 5'd0) begin errors++; $display("FAIL reset_out_flags: got %b expected 00000", out_flags); end
        checks++; if (cf !== 1'b0) begin errors++; $display("FAIL reset_cf: got %b expected 0", cf); end
        checks++; if (op_count !== 4'd0 || err_count !== 4'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", op_count, err_count); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_adc_chain();
        send(4'd1, 8'd200, 8'd100, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", out_valid); end
        checks++; if (out_y !== 8'd44) begin errors++; $display("FAIL add_y: got %0d expected 44", out_y); end
        checks++; if (out_flags !== 5'b01001) begin errors++; $display("FAIL add_flags: got %b expected 01001", out_flags); end
        checks++; if (cf !== 1'b1) begin errors++; $display("FAIL add_cf: got %b expected 1", cf); end
        send(4'd2, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (out_y !== 8'd1) begin errors++; $display("FAIL adc_y: got %0d expected 1", out_y); end
        checks++; if (out_flags !== 5'b01000) begin errors++; $display("FAIL adc_flags: got %b expected 01000", out_flags); end
        checks++; if (cf !== 1'b0) begin errors++; $display("FAIL adc_cf: got %b expected 0", cf); end
        checks++; if (op_count !== 4'd2) begin errors++; $display("FAIL adc_op_count: got %0d expected 2", op_count); end
    endtask

    task automatic test_sub_borrow();
        send(4'd3, 8'd65, 8'd66, 1'b0, 1'b0, 1'b0);
        checks++; if (out_y !== 8'd255) begin errors++; $display("FAIL sub_y: got %0d expected 255", out_y); end
        checks++; if (out_flags !== 5'b00010) begin errors++; $display("FAIL sub_flags: got %b expected 00010", out_flags); end
        checks++; if (cf !== 1'b1) begin errors++; $display("FAIL sub_cf: got %b expected 1", cf); end
        send(4'd3, 8'd65, 8'd65, 1'b0, 1'b0, 1'b0);
        checks++; if (out_y !== 8'd0) begin errors++; $display("FAIL sub_eq_y: got %0d expected 0", out_y); end
        checks++; if (out_flags !== 5'b00100) begin errors++; $display("FAIL sub_eq_flags: got %b expected 00100", out_flags); end
        checks++; if (cf !== 1'b0) begin errors++; $display("FAIL sub_eq_cf: got %b expected 0", cf); end
        // DEC of zero wraps and borrows.
        send(4'd5, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_y !== 8'd255 || out_flags !== 5'b00010 || cf !== 1'b1) begin errors++; $display("FAIL dec_zero: got y=%0d flags=%b cf=%b expected 255/00010/1", out_y, out_flags, cf); end
    endtask

    task automatic test_invalid();
        // cf is 1 from the DEC above; invalid ops must leave it alone.
        send(4'd0, 8'd7, 8'd9, 1'b0, 1'b0, 1'b0);
        checks++; if (out_y !== 8'd0 || out_flags !== 5'b10100) begin errors++; $display("FAIL inv0: got y=%0d flags=%b expected 0/10100", out_y, out_flags); end
        checks++; if (cf !== 1'b1) begin errors++; $display("FAIL inv0_cf: got %b expected 1", cf); end
        send(4'd15, 8'hff, 8'hff, 1'b0, 1'b1, 1'b0);
        checks++; if (out_y !== 8'd0 || out_flags !== 5'b10100) begin errors++; $display("FAIL inv15: got y=%0d flags=%b expected 0/10100", out_y, out_flags); end
        checks++; if (err_count !== 4'd2) begin errors++; $display("FAIL inv_err_count: got %0d expected 2", err_count); end
        checks++; if (cf !== 1'b1) begin errors++; $display("FAIL inv15_cf: got %b expected 1", cf); end
        checks++; if (op_count !== 4'd7) begin errors++; $display("FAIL inv_op_count: got %0d expected 7", op_count); end
    endtask

    task automatic test_clear_cf();
        // cf=1 entering; clear plus ADC using cf sees carry_in=0.
        send(4'd2, 8'd1, 8'd1, 1'b1, 1'b0, 1'b1);
        checks++; if (out_y !== 8'd2 || out_flags !== 5'b01000) begin errors++; $display("FAIL clr_adc: got y=%0d flags=%b expected 2/01000", out_y, out_flags); end
        checks++; if (cf !== 1'b0) begin errors++; $display("FAIL clr_adc_cf: got %b expected 0", cf); end
        send(4'd4, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0);
        send(4'd8, 8'h81, 8'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_y !== 8'h03 || out_flags !== 5'b00000) begin errors++; $display("FAIL rol: got y=%h flags=%b expected 03/00000", out_y, out_flags); end
        checks++; if (cf !== 1'b1) begin errors++; $display("FAIL rol_cf: got %b expected 1", cf); end
        // ROR with clear in the same cycle leaves cf cleared.
        send(4'd9, 8'h01, 8'd0, 1'b0, 1'b0, 1'b1);
        checks++; if (out_y !== 8'h80 || cf !== 1'b0) begin errors++; $display("FAIL ror_clr: got y=%h cf=%b expected 80/0", out_y, cf); end
        send(4'd4, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0);
        // Clear with no accept.
        clear_cf = 1'b1;
        tick();
        clear_cf = 1'b0;
        checks++; if (cf !== 1'b0) begin errors++; $display("FAIL clr_idle_cf: got %b expected 0", cf); end
        checks++; if (op_count !== 4'd12) begin errors++; $display("FAIL clr_op_count: got %0d expected 12", op_count); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_opcode = 4'd4; in_a = 8'd5; in_b = 8'd0; out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_y !== 8'd6) begin errors++; $display("FAIL bp_first: got v=%b y=%0d expected 1/6", out_valid, out_y); end
        in_a = 8'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (in_ready !== 1'b0 || out_y !== 8'd6 || op_count !== 4'd13) begin errors++; $display("FAIL bp_hold%0d: got rdy=%b y=%0d ops=%0d expected 0/6/13", i, in_ready, out_y, op_count); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_pass: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_y !== 8'd10 || op_count !== 4'd14) begin errors++; $display("FAIL bp_b2b: got v=%b y=%0d ops=%0d expected 1/10/14", out_valid, out_y, op_count); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_opcode = 4'd1; in_a = 8'd255; in_b = 8'd1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || cf !== 1'b1) begin errors++; $display("FAIL ar_pre: got v=%b cf=%b expected 1/1", out_valid, cf); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || cf !== 1'b0) begin errors++; $display("FAIL ar_state: got v=%b cf=%b expected 0/0", out_valid, cf); end
        checks++; if (op_count !== 4'd0 || err_count !== 4'd0) begin errors++; $display("FAIL ar_counts: got %0d/%0d expected 0/0", op_count, err_count); end
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_no_emit: got %b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 14; i++) send(4'd6, 8'hf0, 8'h3c, 1'b0, 1'b0, 1'b0);
        checks++; if (op_count !== 4'd14 || out_y !== 8'h30) begin errors++; $display("FAIL sat_14: got ops=%0d y=%h expected 14/30", op_count, out_y); end
        for (int i = 0; i < 2; i++) send(4'd7, 8'h0f, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (op_count !== 4'd15 || out_y !== 8'hf0) begin errors++; $display("FAIL sat_16: got ops=%0d y=%h expected 15/f0", op_count, out_y); end
        send(4'd12, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (op_count !== 4'd15 || err_count !== 4'd1) begin errors++; $display("FAIL sat_hold: got ops=%0d errs=%0d expected 15/1", op_count, err_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_adc_chain();
        test_sub_borrow();
        test_invalid();
        test_clear_cf();
        test_backpressure();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered issue/retire wrapper around the combinational ALU datapath.
- Accepts one ALU command per cycle over a valid/ready handshake and holds a sticky carry flag (CF) so multi-word add/subtract chains work.
- Presents a registered result plus flags downstream over valid/ready.
- Sits between the instruction decoder (upstream) and the register-file writeback (downstream).

Parameters:
BUS_WIDTH, 8, operand/result width in bits (>=2)
CNT_WIDTH, 16, width of the saturating op/error counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  command valid
in_ready  output  1  stage can accept command
in_opcode  input  4  ALU opcode (encoding below)
in_a  input  BUS_WIDTH  operand A
in_b  input  BUS_WIDTH  operand B
in_use_cf  input  1  1: carry_in = CF; 0: carry_in = in_carry
in_carry  input  1  explicit carry_in
clear_cf  input  1  synchronous CF clear
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_y  output  BUS_WIDTH  result
out_flags  output  5  {invalid_op, parity, zero, borrow, carry_out}
cf  output  1  current sticky carry flag
op_count  output  CNT_WIDTH  accepted commands, saturating
err_count  output  CNT_WIDTH  accepted invalid opcodes, saturating

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_y=0, out_flags=0, cf=0, op_count=0, err_count=0. in_ready=1 once rst_n is high.
- Handshake:
  - Accept when in_valid & in_ready.
  - in_ready = !out_valid | out_ready (combinational pass-through ready; no internal buffer beyond the output register).
  - Result is registered: out_* update on the edge that accepts, so latency is 1 cycle.
  - out_valid stays 1 and out_y/out_flags stay stable until out_valid & out_ready.
  - Accept and retire may occur in the same cycle (back-to-back throughput of 1/cycle).
- Opcode encoding (the other two inputs are ignored where not used):
  - 1 ADD: {carry_out,y}=a+b.
  - 2 ADC: {carry_out,y}=a+b+carry_in.
  - 3 SUB: {borrow,y}=a-b (borrow=1 iff a<b).
  - 4 INC: {carry_out,y}=a+1.
  - 5 DEC: {borrow,y}=a-1.
  - 6 AND: y=a&b.
  - 7 NOT: y=~a.
  - 8 ROL: y={a[W-2:0],a[W-1]}.
  - 9 ROR: y={a[0],a[W-1:1]}.
  - All others: y=0, invalid_op=1.
- Flag rules:
  - carry_out/borrow are 0 for any op that does not define them.
  - zero = (y==0).
  - parity = ^y.
  - Invalid ops report zero=1, parity=0.
  - Arithmetic is computed at BUS_WIDTH+1 bits; y wraps modulo 2^BUS_WIDTH.
- CF update (on accept only):
  - ops 1-5: cf <= carry_out|borrow.
  - ops 6-9: cf unchanged.
  - Invalid op: cf unchanged.
- clear_cf:
  - Forces cf to 0 at the next edge when no command is accepted.
  - If a command is accepted in the same cycle, that command sees carry_in=0 when in_use_cf=1, and cf is then loaded from that command's result per the CF rule. A logic/invalid op in that cycle leaves cf=0.
- Counters:
  - op_count +1 per accept.
  - err_count +1 per accepted invalid opcode.
  - Both saturate at all-ones.
- Stall: if out_valid=1 and out_ready=0, in_ready=0; cf and the counters are frozen, and inputs are ignored.
- Reset mid-operation: a pending output is discarded and cf is lost; no result is emitted after reset release until a new accept.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_ADD..OP_ROR), flag bit indices (FLAG_C=0, FLAG_B=1, FLAG_Z=2, FLAG_P=3, FLAG_I=4), and the flag vector width (5).
- One sub-module, alu_core: purely combinational, parameterised by BUS_WIDTH, fully sensitive to opcode/a/b/carry_in, producing y and all five flags.
- alu_issue_stage holds only the handshake, the output register, CF and the counters.

Test Plan:
- ADC chain (W=8): accept ADD a=200 b=100 -> out_y=44, carry_out=1, cf=1; then ADC in_use_cf=1 a=0 b=0 -> out_y=1, cf=0.
- SUB borrow: a=65 b=66 -> out_y=255, borrow=1, zero=0, parity=0, cf=1; a=65 b=65 -> out_y=0, zero=1, cf=0.
- Backpressure: hold out_ready=0 after an accept -> in_ready=0, out_y stable for 5 cycles, op_count unchanged; raise out_ready with in_valid=1 -> same-cycle retire+accept, next result 1 cycle later.
- Invalid opcode 0 and 15 -> out_y=0, out_flags=5'b10100, err_count=2, cf unchanged.
- clear_cf with simultaneous ADC in_use_cf=1 (cf=1), a=1 b=1 -> out_y=2 (carry_in was 0), cf=0; ROL a=8'h81 -> out_y=8'h03, cf unchanged.
- Async reset asserted mid-stream with out_valid=1 -> out_valid=0, cf=0, counters=0 immediately; saturation: preload op_count via 2^CNT_WIDTH accepts (CNT_WIDTH=4) -> holds at 15.
